clk_fwd_div: RTL and testbench
==============================

CLK_FWD_DIV -- requirements
Module: clk_fwd_div

Interface
REQ-001 Parameter DIVISOR, default 8, is the clock divide ratio, integer >= 2.
REQ-002 Parameter LOCK_CYCLES, default 16, is the number of CLK rising edges after reset release before LOCKED asserts, integer >= 1.
REQ-003 One clock, CLK; reset is asynchronous and active-high, RESET.
REQ-004 CLK  input  1  sole clock; all state uses its rising edge, except the DDR falling-edge stage.
REQ-005 RESET  input  1  asynchronous active-high reset of all state.
REQ-006 D1  input  1  DDR data driven on Q during the CLK high phase.
REQ-007 D2  input  1  DDR data driven on Q during the CLK low phase.
REQ-008 DDR_CE  input  1  DDR capture enable; when low, Q holds its pattern.
REQ-009 Q  output  1  DDR output; D1=1, D2=0 forwards CLK; D1=0 gates it off.
REQ-010 CE  output  1  one-CLK-cycle enable pulse, once every DIVISOR cycles.
REQ-011 CLOCK  output  1  registered divided clock, period DIVISOR CLK cycles.
REQ-012 LOCKED  output  1  registered "clock stable" flag.

Function
REQ-013 Divider counter cnt, width clog2(DIVISOR): each rising edge, cnt goes to 0 when cnt = DIVISOR-1, else cnt increments by 1.
REQ-014 CE is combinational, high exactly when cnt = DIVISOR-1.
REQ-015 CLOCK is set on the rising edge where cnt = DIVISOR-1.
REQ-016 CLOCK is cleared on the rising edge where cnt = DIVISOR/2-1 (integer division).
REQ-017 CLOCK therefore stays high floor(DIVISOR/2) cycles and low ceil(DIVISOR/2) cycles (DIVISOR=2: toggles every edge).
REQ-018 CLOCK rises on the same edge that ends the CE cycle.
REQ-019 Lock counter: increments each rising edge, saturates at LOCK_CYCLES, and never wraps.
REQ-020 LOCKED is registered high on the rising edge where the lock counter reaches LOCK_CYCLES, and stays high until RESET.
REQ-021 DDR rising edge with DDR_CE=1: Q <= D1 and internal d2_hold <= D2, both sampled at the same edge.
REQ-022 DDR falling edge: Q <= d2_hold.
REQ-023 DDR_CE=0 at a rising edge: Q <= held D1 value and d2_hold unchanged, so the last captured pattern repeats.
REQ-024 DDR latency: D1 appears on Q just after the sampling rising edge; D2 appears after the following falling edge.
REQ-025 Q is free of glitches other than those at CLK edges; no combinational mux of CLK drives Q.
REQ-026 Divider, lock logic and DDR stage are independent; DDR_CE does not affect CE, CLOCK or LOCKED.

Reset
REQ-027 On RESET high, immediately and asynchronously: cnt=0, CLOCK=0, lock counter=0, LOCKED=0, Q=0, d2_hold=0, held D1=0.
REQ-028 CE is therefore 0 during reset (DIVISOR >= 2).
REQ-029 After RESET falls, the first rising edge starts counting: cnt=1 after edge 1, first CE during the cycle after edge DIVISOR-1, CLOCK first rises at edge DIVISOR.
REQ-030 RESET asserted mid-period or mid-lock aborts immediately; LOCKED drops, and the sequence restarts from zero on release.
REQ-031 RESET asserted while CLK is high forces Q=0 and overrides any pending falling-edge update.

Verification
REQ-032 DIVISOR=8, release reset -> CE high only in cycles where cnt=7 (edge 7, 15, 23...); CLOCK high edges 8-11, low 12-15, period 8.
REQ-033 DIVISOR=5 -> CLOCK high 2 cycles, low 3 cycles; CE one cycle in every 5.
REQ-034 LOCK_CYCLES=16 -> LOCKED=0 through edge 15, 1 from edge 16; assert RESET at edge 20 -> LOCKED=0 at once, back high 16 edges after release.
REQ-035 DDR_CE=1, D1=1, D2=0 -> Q is a copy of CLK after the first rising edge; set D1=0 -> Q stays 0 from the next rising edge.
REQ-036 D1=1, D2=1 then D1=0, D2=1 -> Q=1 constant, then Q low in high phase and high in low phase; DDR_CE=0 -> last pattern repeats regardless of D1/D2.
REQ-037 Assert RESET while CLK high with Q=1 -> Q=0 immediately; CE, CLOCK and LOCKED all 0.

Source files
------------

// File: rtl/clk_fwd_div_if.sv
// -----------------------------------------------------------------------------
// clk_fwd_div_if
// Bundles the DDR data/enable inputs and the divider/lock/DDR outputs of
// clk_fwd_div. CLK and RESET stay plain ports on the module.
//   D1, D2, DDR_CE : DDR high-phase data, low-phase data, capture enable
//   Q              : DDR output
//   CE             : one-cycle enable pulse every DIVISOR cycles
//   CLOCK          : registered divided clock
//   LOCKED         : registered clock-stable flag
// master = block user (drives D1/D2/DDR_CE), slave = clk_fwd_div.
// -----------------------------------------------------------------------------
interface clk_fwd_div_if;
   logic D1;
   logic D2;
   logic DDR_CE;
   logic Q;
   logic CE;
   logic CLOCK;
   logic LOCKED;

   modport master (output D1, D2, DDR_CE, input Q, CE, CLOCK, LOCKED);
   modport slave  (input D1, D2, DDR_CE, output Q, CE, CLOCK, LOCKED);
endinterface

// File: rtl/clk_fwd_div.sv
// -----------------------------------------------------------------------------
// clk_fwd_div
// Clock divider with enable pulse, lock flag and a DDR output stage suitable
// for forwarding CLK (D1=1, D2=0) or gating it off (D1=0).
//   CLK    : sole clock (DDR stage also uses the falling edge)
//   RESET  : asynchronous active-high reset of all state
//   bus    : clk_fwd_div_if.slave (D1, D2, DDR_CE in; Q, CE, CLOCK, LOCKED out)
// Parameters: DIVISOR (>=2) divide ratio, LOCK_CYCLES (>=1) edges to lock.
// -----------------------------------------------------------------------------
module clk_fwd_div #(
   parameter int DIVISOR     = 8,
   parameter int LOCK_CYCLES = 16
) (
   input  logic          CLK,
   input  logic          RESET,
   clk_fwd_div_if.slave  bus
);
   localparam int CW = $clog2(DIVISOR);
   localparam int LW = $clog2(LOCK_CYCLES + 1);

   localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(DIVISOR / 2 - 1);
   localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);
   localparam logic [LW-1:0] LOCK_PRE = LW'(LOCK_CYCLES - 1);

   logic [CW-1:0] r_cnt;
   logic          r_clock;
   logic [LW-1:0] r_lock;
   logic          r_locked;
   logic          r_d1;      // held D1, replayed while DDR_CE is low
   logic          r_d2;      // d2_hold, driven onto Q at the falling edge
   logic          r_qp;      // rising-edge half of the XOR output pair
   logic          r_qn;      // falling-edge half of the XOR output pair
   logic          w_last;
   logic          w_d1_sel;

   // ---------------- divider ----------------
   assign w_last = (r_cnt == CNT_LAST);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_cnt   <= '0;
         r_clock <= 1'b0;
      end else begin
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
         // Set and clear points never coincide for DIVISOR >= 2.
         if (w_last)
            r_clock <= 1'b1;
         else if (r_cnt == CNT_HALF)
            r_clock <= 1'b0;
      end
   end

   // ---------------- lock ----------------
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_lock   <= '0;
         r_locked <= 1'b0;
      end else begin
         if (r_lock < LOCK_MAX)
            r_lock <= r_lock + 1'b1;
         // Registered high on the edge where the counter reaches LOCK_CYCLES.
         if (r_lock == LOCK_PRE)
            r_locked <= 1'b1;
      end
   end

   // ---------------- DDR stage ----------------
   // Q = r_qp ^ r_qn. Each edge rewrites its own flop so the XOR equals the
   // new value; Q therefore only moves right after a CLK edge and CLK itself
   // never passes through logic to reach Q.
   assign w_d1_sel = bus.DDR_CE ? bus.D1 : r_d1;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_d1 <= 1'b0;
         r_d2 <= 1'b0;
         r_qp <= 1'b0;
      end else begin
         if (bus.DDR_CE) begin
            r_d1 <= bus.D1;
            r_d2 <= bus.D2;
         end
         r_qp <= w_d1_sel ^ r_qn;
      end
   end

   always_ff @(negedge CLK or posedge RESET) begin
      if (RESET)
         r_qn <= 1'b0;
      else
         r_qn <= r_d2 ^ r_qp;
   end

   assign bus.Q      = r_qp ^ r_qn;
   assign bus.CE     = w_last;
   assign bus.CLOCK  = r_clock;
   assign bus.LOCKED = r_locked;
endmodule

// File: tb/tb_clk_fwd_div.sv
module tb_clk_fwd_div;
   localparam int DIV_A = 8, LCK_A = 16;
   localparam int DIV_B = 5, LCK_B = 3;

   logic CLK = 1'b0;
   logic RESET = 1'b1;
   int   checks = 0;
   int   failures = 0;

   // reference model: edges since reset release, held DDR pattern
   int   n = 0;
   bit   h1 = 0, h2 = 0;
   bit   in_d1 = 0, in_d2 = 0, in_ce = 0;

   clk_fwd_div_if ifa();
   clk_fwd_div_if ifb();

   clk_fwd_div #(.DIVISOR(DIV_A), .LOCK_CYCLES(LCK_A)) dut_a (.CLK(CLK), .RESET(RESET), .bus(ifa));
   clk_fwd_div #(.DIVISOR(DIV_B), .LOCK_CYCLES(LCK_B)) dut_b (.CLK(CLK), .RESET(RESET), .bus(ifb));

   always #5 CLK = ~CLK;

   function automatic bit exp_ce(int k, int div);
      return (k % div) == div - 1;
   endfunction
   // high for the first floor(div/2) cycles of every period, starting at edge div
   function automatic bit exp_clk(int k, int div);
      return (k >= div) && ((k % div) < div / 2);
   endfunction
   function automatic bit exp_lock(int k, int lc);
      return k >= lc;
   endfunction

   task automatic set_in(bit d1, bit d2, bit ce);
      in_d1 = d1; in_d2 = d2; in_ce = ce;
      ifa.D1 = d1; ifa.D2 = d2; ifa.DDR_CE = ce;
      ifb.D1 = d1; ifb.D2 = d2; ifb.DDR_CE = ce;
   endtask

   task automatic set_rand();
      set_in(1'($urandom), 1'($urandom), 1'($urandom));
   endtask

   // advance to just after the next rising edge and update the model
   task automatic tick();
      @(posedge CLK);
      n++;
      if (in_ce) begin h1 = in_d1; h2 = in_d2; end
      #2;
   endtask

   task automatic low_phase();
      @(negedge CLK);
      #2;
   endtask

   task automatic model_reset();
      n = 0; h1 = 0; h2 = 0;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (ifa.CE !== 1'b0) begin failures++; $display("FAIL reset_ce_a got=%b exp=0", ifa.CE); end
      checks++; if (ifa.CLOCK !== 1'b0) begin failures++; $display("FAIL reset_clock_a got=%b exp=0", ifa.CLOCK); end
      checks++; if (ifa.LOCKED !== 1'b0) begin failures++; $display("FAIL reset_locked_a got=%b exp=0", ifa.LOCKED); end
      checks++; if (ifa.Q !== 1'b0) begin failures++; $display("FAIL reset_q_a got=%b exp=0", ifa.Q); end
      checks++; if (ifb.CE !== 1'b0) begin failures++; $display("FAIL reset_ce_b got=%b exp=0", ifb.CE); end
      checks++; if (ifb.CLOCK !== 1'b0) begin failures++; $display("FAIL reset_clock_b got=%b exp=0", ifb.CLOCK); end
      RESET = 1'b0;
      model_reset();
   endtask

   // runs from reset release to edge 20, resets mid-lock, relocks
   task automatic test_lock();
      while (n < 20) begin
         tick();
         checks++; if (ifa.LOCKED !== exp_lock(n, LCK_A)) begin failures++; $display("FAIL lock_a edge=%0d got=%b exp=%b", n, ifa.LOCKED, exp_lock(n, LCK_A)); end
         checks++; if (ifb.LOCKED !== exp_lock(n, LCK_B)) begin failures++; $display("FAIL lock_b edge=%0d got=%b exp=%b", n, ifb.LOCKED, exp_lock(n, LCK_B)); end
      end
      RESET = 1'b1;
      #1;
      checks++; if (ifa.LOCKED !== 1'b0) begin failures++; $display("FAIL lock_abort_a got=%b exp=0", ifa.LOCKED); end
      checks++; if (ifb.LOCKED !== 1'b0) begin failures++; $display("FAIL lock_abort_b got=%b exp=0", ifb.LOCKED); end
      checks++; if (ifa.CLOCK !== 1'b0 || ifa.CE !== 1'b0) begin failures++; $display("FAIL lock_abort_div got=%b%b exp=00", ifa.CLOCK, ifa.CE); end
      low_phase();
      RESET = 1'b0;
      model_reset();
      for (int i = 0; i < 18; i++) begin
         tick();
         checks++; if (ifa.LOCKED !== exp_lock(n, LCK_A)) begin failures++; $display("FAIL relock_a edge=%0d got=%b exp=%b", n, ifa.LOCKED, exp_lock(n, LCK_A)); end
         checks++; if (ifa.CLOCK !== exp_clk(n, DIV_A)) begin failures++; $display("FAIL relock_clock_a edge=%0d got=%b exp=%b", n, ifa.CLOCK, exp_clk(n, DIV_A)); end
      end
   endtask

   task automatic test_divider(int cycles);
      for (int i = 0; i < cycles; i++) begin
         set_rand();
         tick();
         checks++; if (ifa.CE !== exp_ce(n, DIV_A)) begin failures++; $display("FAIL ce_a edge=%0d got=%b exp=%b", n, ifa.CE, exp_ce(n, DIV_A)); end
         checks++; if (ifa.CLOCK !== exp_clk(n, DIV_A)) begin failures++; $display("FAIL clock_a edge=%0d got=%b exp=%b", n, ifa.CLOCK, exp_clk(n, DIV_A)); end
         checks++; if (ifb.CE !== exp_ce(n, DIV_B)) begin failures++; $display("FAIL ce_b edge=%0d got=%b exp=%b", n, ifb.CE, exp_ce(n, DIV_B)); end
         checks++; if (ifb.CLOCK !== exp_clk(n, DIV_B)) begin failures++; $display("FAIL clock_b edge=%0d got=%b exp=%b", n, ifb.CLOCK, exp_clk(n, DIV_B)); end
      end
   endtask

   // one cycle of DDR checking on both phases for both instances
   task automatic ddr_cycles(int cycles, bit randomize, bit d1, bit d2, bit ce);
      for (int i = 0; i < cycles; i++) begin
         if (randomize) set_rand(); else set_in(d1, d2, ce);
         tick();
         checks++; if (ifa.Q !== h1) begin failures++; $display("FAIL q_high_a edge=%0d got=%b exp=%b", n, ifa.Q, h1); end
         checks++; if (ifb.Q !== h1) begin failures++; $display("FAIL q_high_b edge=%0d got=%b exp=%b", n, ifb.Q, h1); end
         low_phase();
         checks++; if (ifa.Q !== h2) begin failures++; $display("FAIL q_low_a edge=%0d got=%b exp=%b", n, ifa.Q, h2); end
         checks++; if (ifb.Q !== h2) begin failures++; $display("FAIL q_low_b edge=%0d got=%b exp=%b", n, ifb.Q, h2); end
      end
   endtask

   task automatic test_ddr_forward();
      ddr_cycles(6, 1'b0, 1'b1, 1'b0, 1'b1);   // Q mirrors CLK
      ddr_cycles(4, 1'b0, 1'b0, 1'b0, 1'b1);   // gated off
   endtask

   task automatic test_ddr_patterns();
      ddr_cycles(3, 1'b0, 1'b1, 1'b1, 1'b1);   // constant high
      ddr_cycles(3, 1'b0, 1'b0, 1'b1, 1'b1);   // inverted clock
      for (int i = 0; i < 6; i++)              // hold: pattern repeats
         ddr_cycles(1, 1'b0, 1'($urandom), 1'($urandom), 1'b0);
      ddr_cycles(24, 1'b1, 1'b0, 1'b0, 1'b0);  // fully random
   endtask

   task automatic test_reset_clk_high();
      set_in(1'b1, 1'b0, 1'b1);
      tick();
      checks++; if (ifa.Q !== 1'b1) begin failures++; $display("FAIL rst_pre_q got=%b exp=1", ifa.Q); end
      RESET = 1'b1;
      #1;
      checks++; if (ifa.Q !== 1'b0) begin failures++; $display("FAIL rst_high_q_a got=%b exp=0", ifa.Q); end
      checks++; if (ifb.Q !== 1'b0) begin failures++; $display("FAIL rst_high_q_b got=%b exp=0", ifb.Q); end
      checks++; if ({ifa.CE, ifa.CLOCK, ifa.LOCKED} !== 3'b000) begin failures++; $display("FAIL rst_high_outs got=%b exp=000", {ifa.CE, ifa.CLOCK, ifa.LOCKED}); end
      low_phase();
      checks++; if (ifa.Q !== 1'b0) begin failures++; $display("FAIL rst_low_q got=%b exp=0", ifa.Q); end
      RESET = 1'b0;
      model_reset();
      ddr_cycles(3, 1'b0, 1'b1, 1'b0, 1'b1);
   endtask

   initial begin
      set_in(1'b0, 1'b0, 1'b0);
      test_reset();
      test_lock();
      test_divider(40);
      test_ddr_forward();
      test_ddr_patterns();
      test_reset_clk_high();
      test_divider(12);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
